writeback_stage: RTL and testbench
==================================

# writeback_stage

Writeback stage feeding the 16 x 16-bit register file write port (`reg_write_en`, `reg_write_dest`, `reg_write_data`). It accepts results from two producers, the ALU and the load unit, over valid/ready handshakes. It arbitrates them round-robin so that at most one register write happens per cycle, and drives a registered write request into the register file. It also keeps a pending-write scoreboard, a busy bit per register, that the issue logic reads for RAW hazard detection.

## Interface
Parameters:
- DATA_W, 16, result and register width
- ADDR_W, 4, register address width; NREG = 2**ADDR_W = 16

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- alu_valid  input  1  ALU result available
- alu_dest  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU result accepted this cycle (combinational)
- ld_valid  input  1  load result available
- ld_dest  input  ADDR_W  load destination register
- ld_data  input  DATA_W  load data
- ld_ready  output  1  load result accepted this cycle (combinational)
- issue_en  input  1  instruction with a destination issued this cycle
- issue_dest  input  ADDR_W  destination of the issued instruction
- reg_write_en  output  1  register file write strobe, registered
- reg_write_dest  output  ADDR_W  register file write address, registered
- reg_write_data  output  DATA_W  register file write data, registered
- busy  output  NREG  bit i = 1 while register i has an outstanding write

## Operation
- **Transfer rule.** A transfer occurs on a source when valid && ready at a rising edge. Sources must hold dest and data stable while valid && !ready.
- **No backpressure.** The register file never stalls, so ready depends only on arbitration.
  - Only one source valid: it is granted (ready = 1).
  - Neither valid: both ready = 0.
  - Both valid: the grant goes to the source indicated by the `prio` flip-flop (0 = ALU, 1 = load).
- **Priority update.** After any transfer, `prio` is set to point at the source that was not granted. This gives strict alternation under continuous contention. `prio` resets to 0.
- **Write output.** On a transfer edge, reg_write_en <= 1 and reg_write_dest/reg_write_data <= the granted source's dest/data. On an edge with no transfer, reg_write_en <= 0 and dest/data hold their previous values.
- **Scoreboard set.** On each edge, if issue_en: busy[issue_dest] <= 1.
- **Scoreboard clear.** On each edge, if reg_write_en == 1: busy[reg_write_dest] <= 0. The clear happens on the same edge that the register file commits the write.
- **Same-edge set and clear.** If both target the same register on one edge, the set wins, because a newer producer has been issued.
- **Ordering.** Writes to the same destination are not reordered across sources; ordering is the issue logic's responsibility. The block writes whatever it is given.

## Timing
- **Reset.** While rst = 0, asynchronously: reg_write_en = 0, reg_write_dest = 0, reg_write_data = 0, busy = 0, prio = 0. alu_ready and ld_ready are forced to 0 while in reset.
- **Latency.** A transfer at edge N gives reg_write_en = 1 during cycle N..N+1, and the register file holds the value after edge N+1. busy clears at edge N+1, so the read-after-write result is visible from cycle N+1 onward.
- **Throughput.** One write per cycle sustained. With both sources continuously valid, grants alternate ALU, load, ALU, and so on.
- **Strobe width.** reg_write_en is a one-cycle pulse per transfer; back-to-back transfers keep it high continuously.
- **Mid-operation reset.** Asserting rst mid-operation drops any in-flight write; the write is not committed. Outputs return to their reset values immediately, without waiting for a clock edge.
- **Reset release.** The first transfer is possible at the first rising edge after rst goes high.

## Test plan
- **Reset values.** Hold rst = 0 with alu_valid = 1 -> alu_ready = 0, reg_write_en = 0, busy = 16'h0000. Release rst -> alu_ready = 1 in the same cycle.
- **Single ALU write.** issue_en, dest 3, at edge 0. alu_valid with dest 3, data 16'hBEEF, at edge 1. -> reg_write_en = 1 with dest 3, data BEEF after edge 1; busy[3] = 1 after edge 0 and 0 after edge 2; register file reads 3 = BEEF after edge 2.
- **Contention.** Both sources valid for 4 cycles (ALU dest 1 data 1111, load dest 2 data 2222) -> write sequence is dest 1, 2, 1, 2, with alu_ready and ld_ready alternating starting with ALU.
- **Set/clear collision.** A write of dest 5 is committing (reg_write_en = 1, dest 5) while issue_en with issue_dest 5 arrives on the same edge -> busy[5] stays 1.
- **Reset mid-write.** Assert rst in the cycle reg_write_en = 1 (dest 7, data 0x1234) -> reg_write_en drops immediately and register 7 is unchanged.
- **All registers.** Sweep writes to registers 0..15 with data = 16'hA000 + i from alternating sources -> register file ports 1 and 2 read back A000 through A00F, and busy returns to 0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: round-robin arbiter between ALU and load results, a registered
// register-file write port, and a per-register pending-write scoreboard for RAW checks.
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_dest,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  output logic                     reg_write_en,
  output logic [ADDR_W-1:0]        reg_write_dest,
  output logic [DATA_W-1:0]        reg_write_data,
  output logic [(2**ADDR_W)-1:0]   busy
);

  localparam int NREG = 2**ADDR_W;

  logic              r_prio;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_dest;
  logic [DATA_W-1:0] r_wr_data;
  logic [NREG-1:0]   r_busy;

  logic              w_alu_grant;
  logic              w_ld_grant;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_dest;
  logic [DATA_W-1:0] w_sel_data;
  logic [NREG-1:0]   w_busy_next;

  // Grant: a lone requester always wins; under contention r_prio picks (0 = ALU, 1 = load).
  always_comb begin
    w_alu_grant = 1'b0;
    w_ld_grant  = 1'b0;
    if (rst && alu_valid && ld_valid) begin
      w_alu_grant = ~r_prio;
      w_ld_grant  = r_prio;
    end else if (rst) begin
      w_alu_grant = alu_valid;
      w_ld_grant  = ld_valid;
    end else begin
      w_alu_grant = 1'b0;
      w_ld_grant  = 1'b0;
    end
  end

  // Select the granted source's payload for the write register.
  always_comb begin
    w_sel_dest = alu_dest;
    w_sel_data = alu_data;
    if (w_ld_grant) begin
      w_sel_dest = ld_dest;
      w_sel_data = ld_data;
    end else begin
      w_sel_dest = alu_dest;
      w_sel_data = alu_data;
    end
  end

  assign w_xfer    = w_alu_grant | w_ld_grant;
  assign alu_ready = w_alu_grant;
  assign ld_ready  = w_ld_grant;

  // Scoreboard next state: clear for the committing write first, so a same-edge issue wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_wr_en) begin
      w_busy_next[r_wr_dest] = 1'b0;
    end else begin
      w_busy_next = r_busy;
    end
    if (issue_en) begin
      w_busy_next[issue_dest] = 1'b1;
    end else begin
      w_busy_next[issue_dest] = w_busy_next[issue_dest];
    end
  end

  // Write request register and round-robin pointer; dest/data hold on idle edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_dest <= {ADDR_W{1'b0}};
      r_wr_data <= {DATA_W{1'b0}};
    end else if (w_xfer) begin
      r_prio    <= w_alu_grant;
      r_wr_en   <= 1'b1;
      r_wr_dest <= w_sel_dest;
      r_wr_data <= w_sel_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign reg_write_en   = r_wr_en;
  assign reg_write_dest = r_wr_dest;
  assign reg_write_data = r_wr_data;
  assign busy           = r_busy;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic
// compared against a timestamp-based scoreboard and grant-history reference model.
module tb_writeback_stage;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dest;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic [NREG-1:0]   busy;

  writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(ld_ready),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register file, fed only by the DUT write port.
  logic [DATA_W-1:0] tb_rf [NREG];
  always @(posedge clk) if (reg_write_en) tb_rf[reg_write_dest] <= reg_write_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit                m_en;
  logic [ADDR_W-1:0] m_dest;
  logic [DATA_W-1:0] m_data;
  bit                m_last_ld;
  int                issue_t [NREG];
  int                clear_t [NREG];
  int                edge_n = 0;
  logic [DATA_W-1:0] m_rf [NREG];
  bit                m_rf_ok [NREG];

  function automatic logic [NREG-1:0] model_busy();
    logic [NREG-1:0] b;
    for (int r = 0; r < NREG; r++) b[r] = (issue_t[r] >= 0) && (issue_t[r] >= clear_t[r]);
    return b;
  endfunction

  function automatic bit want_alu();
    return rst && alu_valid && (!ld_valid || m_last_ld);
  endfunction

  function automatic bit want_ld();
    return rst && ld_valid && (!alu_valid || !m_last_ld);
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_dest = '0; m_data = '0; m_last_ld = 1'b1;
    for (int r = 0; r < NREG; r++) begin issue_t[r] = -1; clear_t[r] = -1; end
  endtask

  task automatic cycle();
    bit ga, gl;
    ga = want_alu();
    gl = want_ld();
    @(posedge clk);
    edge_n++;
    if (rst) begin
      if (m_en) begin
        clear_t[m_dest] = edge_n;
        m_rf[m_dest] = m_data;
        m_rf_ok[m_dest] = 1'b1;
      end
      if (issue_en) issue_t[issue_dest] = edge_n;
      if (ga) begin
        m_en = 1'b1; m_dest = alu_dest; m_data = alu_data; m_last_ld = 1'b0;
      end else if (gl) begin
        m_en = 1'b1; m_dest = ld_dest; m_data = ld_data; m_last_ld = 1'b1;
      end else begin
        m_en = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; issue_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    cycle();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_inputs();
    alu_valid = 1'b1; alu_dest = 4'd4; alu_data = 16'h0044;
    model_reset();
    cycle(); cycle();
    n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL reset_alu_ready got %0b want 0", alu_ready); end
    n_checks++; if (reg_write_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %0b want 0", reg_write_en); end
    n_checks++; if (busy !== 16'h0000) begin n_errors++; $display("FAIL reset_busy got %h want 0000", busy); end
    n_checks++; if ({reg_write_dest, reg_write_data} !== 20'h0) begin n_errors++; $display("FAIL reset_wr_payload got %h/%h want 0/0000", reg_write_dest, reg_write_data); end
    rst = 1'b1;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL release_alu_ready got %0b want 1", alu_ready); end
    cycle();
    alu_valid = 1'b0;
    n_checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 4'd4 || reg_write_data !== 16'h0044) begin
      n_errors++; $display("FAIL release_first_write got %0b/%h/%h want 1/4/0044", reg_write_en, reg_write_dest, reg_write_data); end
    cycle();
  endtask

  task automatic test_single_alu();
    issue_en = 1'b1; issue_dest = 4'd3;
    #1; cycle();
    issue_en = 1'b0;
    n_checks++; if (busy[3] !== 1'b1) begin n_errors++; $display("FAIL single_busy_set got %0b want 1", busy[3]); end
    alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 16'hBEEF;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL single_alu_ready got %0b want 1", alu_ready); end
    cycle();
    alu_valid = 1'b0;
    n_checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 4'd3 || reg_write_data !== 16'hBEEF) begin
      n_errors++; $display("FAIL single_write got %0b/%h/%h want 1/3/beef", reg_write_en, reg_write_dest, reg_write_data); end
    n_checks++; if (busy[3] !== 1'b1) begin n_errors++; $display("FAIL single_busy_hold got %0b want 1", busy[3]); end
    cycle();
    n_checks++; if (busy[3] !== 1'b0) begin n_errors++; $display("FAIL single_busy_clear got %0b want 0", busy[3]); end
    n_checks++; if (tb_rf[3] !== 16'hBEEF) begin n_errors++; $display("FAIL single_rf got %h want beef", tb_rf[3]); end
    n_checks++; if (reg_write_en !== 1'b0) begin n_errors++; $display("FAIL single_strobe_pulse got %0b want 0", reg_write_en); end
  endtask

  task automatic test_contention();
    do_reset();
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 16'h1111;
    ld_valid  = 1'b1; ld_dest  = 4'd2; ld_data  = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (alu_ready !== (k % 2 == 0) || ld_ready !== (k % 2 == 1)) begin
        n_errors++; $display("FAIL contention_ready[%0d] got %0b%0b want %0b%0b", k, alu_ready, ld_ready, (k % 2 == 0), (k % 2 == 1)); end
      cycle();
      n_checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== ((k % 2 == 0) ? 4'd1 : 4'd2) || reg_write_data !== m_data) begin
        n_errors++; $display("FAIL contention_write[%0d] got %0b/%h/%h want 1/%h/%h", k, reg_write_en, reg_write_dest, reg_write_data, m_dest, m_data); end
    end
    idle_inputs();
    cycle();
    n_checks++; if (reg_write_en !== 1'b0 || reg_write_dest !== 4'd2 || reg_write_data !== 16'h2222) begin
      n_errors++; $display("FAIL contention_idle_hold got %0b/%h/%h want 0/2/2222", reg_write_en, reg_write_dest, reg_write_data); end
  endtask

  task automatic test_collision();
    issue_en = 1'b1; issue_dest = 4'd5;
    #1; cycle();
    issue_en = 1'b0;
    alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 16'h5555;
    #1; cycle();
    alu_valid = 1'b0;
    issue_en = 1'b1; issue_dest = 4'd5;
    n_checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 4'd5) begin
      n_errors++; $display("FAIL collision_commit got %0b/%h want 1/5", reg_write_en, reg_write_dest); end
    #1; cycle();
    issue_en = 1'b0;
    n_checks++; if (busy[5] !== 1'b1) begin n_errors++; $display("FAIL collision_set_wins got %0b want 1", busy[5]); end
    n_checks++; if (busy !== model_busy()) begin n_errors++; $display("FAIL collision_busy got %h want %h", busy, model_busy()); end
    ld_valid = 1'b1; ld_dest = 4'd5; ld_data = 16'h5A5A;
    #1; cycle();
    ld_valid = 1'b0;
    cycle();
    n_checks++; if (busy[5] !== 1'b0) begin n_errors++; $display("FAIL collision_second_clear got %0b want 0", busy[5]); end
  endtask

  task automatic test_reset_mid_write();
    alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 16'h0777;
    #1; cycle();
    alu_valid = 1'b0;
    cycle();
    n_checks++; if (tb_rf[7] !== 16'h0777) begin n_errors++; $display("FAIL midrst_prewrite got %h want 0777", tb_rf[7]); end
    alu_valid = 1'b1; alu_data = 16'h1234;
    issue_en = 1'b1; issue_dest = 4'd9;
    #1; cycle();
    idle_inputs();
    n_checks++; if (reg_write_en !== 1'b1 || reg_write_data !== 16'h1234 || busy[9] !== 1'b1) begin
      n_errors++; $display("FAIL midrst_inflight got %0b/%h busy9=%0b want 1/1234 busy9=1", reg_write_en, reg_write_data, busy[9]); end
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++; if (reg_write_en !== 1'b0 || reg_write_dest !== 4'd0 || reg_write_data !== 16'h0000) begin
      n_errors++; $display("FAIL midrst_async_outputs got %0b/%h/%h want 0/0/0000", reg_write_en, reg_write_dest, reg_write_data); end
    n_checks++; if (busy !== 16'h0000) begin n_errors++; $display("FAIL midrst_busy got %h want 0000", busy); end
    cycle();
    rst = 1'b1;
    cycle();
    n_checks++; if (tb_rf[7] !== 16'h0777) begin n_errors++; $display("FAIL midrst_not_committed got %h want 0777", tb_rf[7]); end
  endtask

  task automatic test_all_regs();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < NREG; i++) begin
      issue_en = 1'b1; issue_dest = 4'(i);
      #1; cycle();
      issue_en = 1'b0;
      v = 16'hA000 + 16'(i);
      if (i % 2 == 0) begin alu_valid = 1'b1; alu_dest = 4'(i); alu_data = v; end
      else begin ld_valid = 1'b1; ld_dest = 4'(i); ld_data = v; end
      #1;
      n_checks++; if (alu_ready !== (i % 2 == 0) || ld_ready !== (i % 2 == 1)) begin
        n_errors++; $display("FAIL sweep_ready[%0d] got %0b%0b", i, alu_ready, ld_ready); end
      cycle();
      idle_inputs();
    end
    cycle(); cycle();
    for (int i = 0; i < NREG; i++) begin
      v = 16'hA000 + 16'(i);
      n_checks++; if (tb_rf[i] !== v) begin n_errors++; $display("FAIL sweep_rf[%0d] got %h want %h", i, tb_rf[i], v); end
    end
    n_checks++; if (busy !== 16'h0000) begin n_errors++; $display("FAIL sweep_busy got %h want 0000", busy); end
  endtask

  task automatic test_random();
    bit ga, gl;
    ga = 1'b0; gl = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(alu_valid && !ga)) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_dest = 4'($urandom); alu_data = 16'($urandom);
      end
      if (!(ld_valid && !gl)) begin
        ld_valid = ($urandom_range(0, 9) < 5);
        ld_dest = 4'($urandom); ld_data = 16'($urandom);
      end
      issue_en = ($urandom_range(0, 3) == 0);
      issue_dest = 4'($urandom);
      #1;
      ga = want_alu();
      gl = want_ld();
      n_checks++; if (alu_ready !== ga || ld_ready !== gl) begin
        n_errors++; $display("FAIL rand_ready[%0d] got %0b%0b want %0b%0b", c, alu_ready, ld_ready, ga, gl); end
      cycle();
      n_checks++; if (reg_write_en !== m_en || reg_write_dest !== m_dest || reg_write_data !== m_data) begin
        n_errors++; $display("FAIL rand_write[%0d] got %0b/%h/%h want %0b/%h/%h", c, reg_write_en, reg_write_dest, reg_write_data, m_en, m_dest, m_data); end
      n_checks++; if (busy !== model_busy()) begin
        n_errors++; $display("FAIL rand_busy[%0d] got %h want %h", c, busy, model_busy()); end
    end
    idle_inputs();
    cycle(); cycle();
    for (int r = 0; r < NREG; r++) begin
      if (m_rf_ok[r]) begin
        n_checks++; if (tb_rf[r] !== m_rf[r]) begin n_errors++; $display("FAIL rand_rf[%0d] got %h want %h", r, tb_rf[r], m_rf[r]); end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    ld_valid = 1'b0; ld_dest = '0; ld_data = '0;
    issue_en = 1'b0; issue_dest = '0;
    for (int r = 0; r < NREG; r++) begin m_rf[r] = '0; m_rf_ok[r] = 1'b0; end
    test_reset();
    test_single_alu();
    test_contention();
    test_collision();
    test_reset_mid_write();
    test_all_regs();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
